// File: rtl/inst_queue_pkg.sv
// Shared types and helpers for the fetch/decode instruction queue.
package inst_queue_pkg;

  localparam int INST_W_DEF = 32;

  typedef logic [INST_W_DEF-1:0] inst_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/inst_compact.sv
// Prefix popcount of sparse lane valids: per-lane write offset plus total count.
module inst_compact
  import inst_queue_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int NUM_W = clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]            vld_i,
  output logic [IN_W-1:0][NUM_W-1:0] off_o,
  output logic [NUM_W-1:0]           num_o
);

  logic [NUM_W-1:0] acc_s;

  // Running count of valid lanes below each lane gives its compacted slot.
  always_comb begin
    acc_s = '0;
    off_o = '0;
    for (int k = 0; k < IN_W; k++) begin
      off_o[k] = acc_s;
      acc_s    = acc_s + NUM_W'(vld_i[k]);
    end
    num_o = acc_s;
  end

endmodule

// File: rtl/inst_queue_chk.sv
// Simulation-only occupancy check for the instruction queue.
module inst_queue_chk #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input logic             clock,
  input logic             reset,
  input logic [CNT_W-1:0] count_i
);

  // Occupancy must never exceed the number of storage entries.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count_i <= CNT_W'(DEPTH))
      else $error("inst_queue: occupancy %0d above DEPTH %0d", count_i, DEPTH);
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode decoupling queue: compacting multi-lane enqueue into a circular
// buffer, variable-count in-order dequeue, back-pressure, almost-full and flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 4,
  parameter int INST_W    = INST_W_DEF,
  parameter int AFULL_THR = 24,
  localparam int PTR_W    = clog2(DEPTH),
  localparam int CNT_W    = clog2(DEPTH + 1),
  localparam int DCNT_W   = clog2(OUT_W + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic [IN_W-1:0]         enq_vld_i,
  input  logic [IN_W*INST_W-1:0]  enq_inst_i,
  output logic                    enq_rdy_o,
  output logic [OUT_W-1:0]        deq_vld_o,
  output logic [OUT_W*INST_W-1:0] deq_inst_o,
  input  logic [DCNT_W-1:0]       deq_cnt_i,
  output logic [CNT_W-1:0]        count_o,
  output logic                    afull_o,
  output logic                    empty_o
);

  localparam int NUM_W = clog2(IN_W + 1);

  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
    $fatal(1, "inst_queue: DEPTH must be a power of two");
  end
  if (DEPTH < 2 * IN_W) begin : g_bad_depth_min
    $fatal(1, "inst_queue: DEPTH must be at least 2*IN_W");
  end
  if (OUT_W > DEPTH) begin : g_bad_out_w
    $fatal(1, "inst_queue: OUT_W must not exceed DEPTH");
  end

  logic [INST_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_rdy_q, enq_rdy_d;
  logic             afull_q, afull_d;
  logic             empty_q, empty_d;

  logic [IN_W-1:0][NUM_W-1:0] enq_off_s;
  logic [NUM_W-1:0]           enq_num_s;
  logic                       enq_fire_s;
  logic [CNT_W-1:0]           deq_req_s;
  logic [CNT_W-1:0]           deq_lim_s;
  logic [CNT_W-1:0]           deq_num_s;
  logic [PTR_W-1:0]           wr_idx_s [IN_W];

  inst_compact #(
    .IN_W  (IN_W),
    .NUM_W (NUM_W)
  ) u_compact (
    .vld_i (enq_vld_i),
    .off_o (enq_off_s),
    .num_o (enq_num_s)
  );

  // Clip the decode request to both the occupancy and the output width.
  always_comb begin
    deq_req_s = CNT_W'(deq_cnt_i);
    deq_lim_s = (count_q < CNT_W'(OUT_W)) ? count_q : CNT_W'(OUT_W);
    deq_num_s = (deq_req_s < deq_lim_s) ? deq_req_s : deq_lim_s;
  end

  // Pointer/occupancy next state; flush wins over both enqueue and dequeue.
  always_comb begin
    enq_fire_s = enq_rdy_q & ~flush_i;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(deq_num_s);
      if (enq_fire_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_num_s);
        count_d  = count_q + CNT_W'(enq_num_s) - deq_num_s;
      end else begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q - deq_num_s;
      end
    end
    enq_rdy_d = (CNT_W'(DEPTH) - count_d) >= CNT_W'(IN_W);
    afull_d   = count_d >= CNT_W'(AFULL_THR);
    empty_d   = (count_d == '0);
  end

  // Storage slot for each enqueue lane after compaction.
  always_comb begin
    for (int k = 0; k < IN_W; k++) begin
      wr_idx_s[k] = wr_ptr_q + PTR_W'(enq_off_s[k]);
    end
  end

  // Control state; status flags are registered alongside the count they summarise.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      enq_rdy_q <= 1'b1;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      enq_rdy_q <= enq_rdy_d;
      afull_q   <= afull_d;
      empty_q   <= empty_d;
    end
  end

  // Instruction storage, intentionally left unreset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < IN_W; k++) begin
      if (enq_fire_s && enq_vld_i[k]) begin
        mem_q[wr_idx_s[k]] <= enq_inst_i[k*INST_W +: INST_W];
      end
    end
  end

  // Oldest entries in lane order; invalid lanes are forced to zero.
  always_comb begin
    deq_vld_o  = '0;
    deq_inst_o = '0;
    for (int k = 0; k < OUT_W; k++) begin
      deq_vld_o[k] = CNT_W'(k) < count_q;
      deq_inst_o[k*INST_W +: INST_W] = deq_vld_o[k] ? mem_q[rd_ptr_q + PTR_W'(k)] : '0;
    end
  end

  assign enq_rdy_o = enq_rdy_q;
  assign count_o   = count_q;
  assign afull_o   = afull_q;
  assign empty_o   = empty_q;

  inst_queue_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clock   (clock),
    .reset   (reset),
    .count_i (count_q)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Directed plus randomised bench for inst_queue with a FIFO scoreboard of expected entries.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH     = 32;
  localparam int IN_W      = 8;
  localparam int OUT_W     = 4;
  localparam int INST_W    = 32;
  localparam int AFULL_THR = 24;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    flush_i = 1'b0;
  logic [IN_W-1:0]         enq_vld_i = '0;
  logic [IN_W*INST_W-1:0]  enq_inst_i = '0;
  logic                    enq_rdy_o;
  logic [OUT_W-1:0]        deq_vld_o;
  logic [OUT_W*INST_W-1:0] deq_inst_o;
  logic [2:0]              deq_cnt_i = '0;
  logic [5:0]              count_o;
  logic                    afull_o;
  logic                    empty_o;

  inst_t exp_q[$];
  int    checks = 0;
  int    passed = 0;

  inst_queue #(
    .DEPTH     (DEPTH),
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .INST_W    (INST_W),
    .AFULL_THR (AFULL_THR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (flush_i),
    .enq_vld_i  (enq_vld_i),
    .enq_inst_i (enq_inst_i),
    .enq_rdy_o  (enq_rdy_o),
    .deq_vld_o  (deq_vld_o),
    .deq_inst_o (deq_inst_o),
    .deq_cnt_i  (deq_cnt_i),
    .count_o    (count_o),
    .afull_o    (afull_o),
    .empty_o    (empty_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    int         sz;
    logic [3:0] ev;
    inst_t      e;
    sz = exp_q.size();
    chk({tag, ".count"}, 64'(count_o), 64'(sz));
    chk({tag, ".empty"}, 64'(empty_o), 64'(sz == 0));
    chk({tag, ".afull"}, 64'(afull_o), 64'(sz >= AFULL_THR));
    chk({tag, ".rdy"}, 64'(enq_rdy_o), 64'((DEPTH - sz) >= IN_W));
    for (int k = 0; k < OUT_W; k++) ev[k] = (k < sz);
    chk({tag, ".vld"}, 64'(deq_vld_o), 64'(ev));
    for (int k = 0; k < OUT_W; k++) begin
      e = (k < sz) ? exp_q[k] : 32'h0;
      chk($sformatf("%s.lane%0d", tag, k), 64'(deq_inst_o[k*INST_W +: INST_W]), 64'(e));
    end
  endtask

  // Drive one cycle, update the scoreboard, then check after the edge.
  task automatic cycle(input string tag, input logic [7:0] vld, input logic [31:0] base,
                       input int dcnt, input logic fl, input logic rs);
    int n;
    bit rdy;
    enq_vld_i = vld;
    for (int k = 0; k < IN_W; k++) enq_inst_i[k*INST_W +: INST_W] = base + 32'(k);
    deq_cnt_i = 3'(dcnt);
    flush_i   = fl;
    reset     = rs;
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      rdy = (DEPTH - exp_q.size()) >= IN_W;
      n   = dcnt;
      if (n > OUT_W) n = OUT_W;
      if (n > exp_q.size()) n = exp_q.size();
      repeat (n) void'(exp_q.pop_front());
      if (rdy) begin
        for (int k = 0; k < IN_W; k++) if (vld[k]) exp_q.push_back(base + 32'(k));
      end
    end
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    cycle("rst0", 8'h00, 32'h0, 0, 1'b0, 1'b1);
    cycle("rst1", 8'h00, 32'h0, 0, 1'b0, 1'b1);
    cycle("idle", 8'h00, 32'h0, 0, 1'b0, 1'b0);

    cycle("sparse", 8'b1010_0101, 32'h100, 0, 1'b0, 1'b0);
    cycle("drain_sparse", 8'h00, 32'h0, 4, 1'b0, 1'b0);

    cycle("fill8", 8'hFF, 32'h200, 0, 1'b0, 1'b0);
    cycle("fill16", 8'hFF, 32'h210, 0, 1'b0, 1'b0);
    cycle("fill20", 8'h0F, 32'h220, 0, 1'b0, 1'b0);
    cycle("fill24", 8'h0F, 32'h230, 0, 1'b0, 1'b0);
    cycle("fill28", 8'h0F, 32'h240, 0, 1'b0, 1'b0);
    cycle("drop", 8'hFF, 32'h250, 0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle($sformatf("drain%0d", i), 8'h00, 32'h0, 4, 1'b0, 1'b0);

    cycle("wrap_enq", 8'hFF, 32'h300, 0, 1'b0, 1'b0);
    cycle("wrap_deq0", 8'h00, 32'h0, 4, 1'b0, 1'b0);
    cycle("wrap_deq1", 8'h00, 32'h0, 4, 1'b0, 1'b0);

    cycle("to6", 8'h3F, 32'h400, 0, 1'b0, 1'b0);
    cycle("enq5_deq3", 8'b1101_0101, 32'h410, 3, 1'b0, 1'b0);
    cycle("deq4", 8'h00, 32'h0, 4, 1'b0, 1'b0);
    cycle("deq2", 8'h00, 32'h0, 2, 1'b0, 1'b0);
    cycle("clip", 8'h00, 32'h0, 4, 1'b0, 1'b0);
    cycle("overreq", 8'h00, 32'h0, 7, 1'b0, 1'b0);

    cycle("pre_flush8", 8'hFF, 32'h500, 0, 1'b0, 1'b0);
    cycle("pre_flush12", 8'h0F, 32'h510, 0, 1'b0, 1'b0);
    cycle("flush", 8'hFF, 32'h520, 4, 1'b1, 1'b0);
    cycle("post_flush", 8'h00, 32'h0, 0, 1'b0, 1'b0);

    cycle("pre_rst", 8'hFF, 32'h600, 0, 1'b0, 1'b0);
    cycle("mid_rst", 8'hFF, 32'h610, 2, 1'b1, 1'b1);
    cycle("post_rst", 8'hFF, 32'h620, 0, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      cycle($sformatf("rnd%0d", i), 8'($urandom), 32'h1000 + 32'(i * 16),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 15) == 0), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
